instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the RISC-V core. Owns the PC and issues in-order word requests to instruction memory.
//  Buffers returned words in a small FIFO and hands {instr, pc} to decode (imm_gen, control) via valid/ready.
//  Accepts branch/jump redirects from execute: squashes buffered and in-flight fetches, restarts at the new PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of the first fetch after reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              fetch-buffer entries; power of 2, >= 2; also caps in-flight requests
// PORTS
//  clk             in   1   core clock, all state on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address (= PC)
//  imem_rsp_valid  in   1   response word valid; responses return in request order, latency >= 1 cycle
//  imem_rsp_data   in   32  fetched instruction word
//  redirect_valid  in   1   single-cycle pulse: taken branch / JAL / JALR
//  redirect_pc     in   32  redirect target
//  out_valid       out  1   {out_instr, out_pc} valid to decode
//  out_ready       in   1   decode consumes this cycle
//  out_instr       out  32  instruction word
//  out_pc          out  32  address of out_instr
// BEHAVIOUR
//  - Reset (async on rst_n low): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; out_valid=0,
//    out_instr=NOP (32'h0000_0013), out_pc=0, imem_req_valid=0. First request in the first cycle after release.
//  - req_fire = imem_req_valid & imem_req_ready; rsp_fire = imem_rsp_valid; out_fire = out_valid & out_ready.
//  - imem_req_valid = ~redirect_valid & (outstanding + fifo_count < FIFO_DEPTH). Combinational; memory
//    tolerates withdrawal of an unaccepted request. imem_req_addr = pc.
//  - On req_fire: pc <= pc + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); push pc into a PC-tag queue; outstanding++.
//  - On rsp_fire with drop_cnt != 0: discard word, drop_cnt--, outstanding--, pop tag queue.
//  - On rsp_fire with drop_cnt == 0: push {imem_rsp_data, tag-queue head} into FIFO; outstanding--, pop tag.
//    Credit rule guarantees no FIFO overflow; an overflow is an assertion failure.
//  - Output is registered from the FIFO head: word returned in cycle N is visible at out_valid in cycle N+1.
//    out_instr/out_pc hold stable while out_valid & ~out_ready. Simultaneous push and pop supported at any count.
//  - Redirect (redirect_valid=1 in cycle N): pc <= {redirect_pc[31:2], 2'b00}; FIFO flushed (out_valid=0 in N+1,
//    out_fire in cycle N is ignored by decode contract); no request issued in N;
//    drop_cnt <= outstanding - rsp_fire (any response in cycle N discarded); tag queue kept in sync.
//    First new-stream request issued in N+1 to the aligned target.
//  - Back-to-back redirects: each recomputes drop_cnt from current outstanding; last target wins.
//  - Counters: outstanding and drop_cnt are $clog2(FIFO_DEPTH)+1 bits; both never exceed FIFO_DEPTH.
//  - Reset mid-operation: all state cleared immediately; in-flight memory responses after release are the
//    memory's responsibility (memory is reset by the same rst_n).
// STRUCTURE
//  - riscv_pkg: NOP_INSTR = 32'h0000_0013, XLEN = 32, PC_STEP = 4 (shared with decode/imm_gen opcode constants).
//  - Sub-module fetch_fifo (DEPTH, WIDTH): sync FIFO with push/pop/flush, count, full/empty, registered head.
//    Instantiated twice: WIDTH=64 for {instr,pc} buffer, WIDTH=32 for the PC-tag queue.
//  - Top: PC register, credit/outstanding/drop counters, request/response steering.
// TESTING
//  1 Reset: rst_n low -> out_valid=0, out_instr=0x00000013, imem_req_valid=0; release -> req addr 0x0 next cycle.
//  2 Streaming, 1-cycle memory, out_ready=1: addrs 0x0,0x4,0x8,... one per cycle; out_pc tracks with 2-cycle lag.
//  3 Backpressure: out_ready=0 -> exactly FIFO_DEPTH=2 requests accepted, then imem_req_valid=0; out holds 0x0
//    entry stable; out_ready=1 -> drains in order 0x0,0x4, requests resume at 0x8.
//  4 Redirect with 2 in flight: redirect_pc=0x103 -> both old responses dropped, next req addr 0x100,
//    first out_pc=0x100; no old-stream word ever reaches out_valid.
//  5 Redirect and rsp_valid same cycle, plus second redirect to 0x200 one cycle later -> all old words
//    dropped, drop_cnt returns to 0, first output out_pc=0x200.
//  6 PC wrap: RESET_PC=0xFFFF_FFF8 -> req addrs 0xFFFF_FFF8,0xFFFF_FFFC,0x0; rst_n pulse mid-stream -> state cleared.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch-to-decode payload type.
package riscv_pkg;
    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    // A pop frees a slot in the same cycle, so push is legal even at full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign full    = (count == DEPTH_W);
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop && !flush));
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word requests, buffers {instr, pc} for decode.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = FIFO_DEPTH[CW:0];

    logic [XLEN-1:0]   pc, tag_head;
    logic [CW-1:0]     outstanding, drop_cnt, data_count, tag_count;
    logic [2*XLEN-1:0] data_head;
    fetch_entry_t      head_entry, push_entry;
    logic data_empty, data_full, tag_empty, tag_full;
    logic credit_ok, req_fire, rsp_fire, keep_rsp, out_fire;
    logic unused_ok;

    // Every in-flight request owns a buffer slot, so responses can never overflow the FIFO.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, data_count}) < CREDITS;
    assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid;
    assign keep_rsp = rsp_fire & (drop_cnt == '0) & ~redirect_valid;
    assign out_fire = out_valid & out_ready;

    assign push_entry = '{instr: imem_rsp_data, pc: tag_head};
    assign head_entry = fetch_entry_t'(data_head);
    assign out_valid  = ~data_empty;
    assign out_instr  = out_valid ? head_entry.instr : NOP_INSTR;
    assign out_pc     = out_valid ? head_entry.pc : '0;
    assign unused_ok  = &{1'b0, data_full, tag_count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                pc       <= align_pc(redirect_pc);
                drop_cnt <= outstanding - CW'(rsp_fire);
            end else begin
                if (req_fire) pc <= pc + PC_STEP;
                if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep_rsp),
        .push_data (push_entry),
        .pop       (out_fire & ~redirect_valid),
        .flush     (redirect_valid),
        .head      (data_head),
        .count     (data_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    // Tags are never flushed: dropped responses still return and must pop their tag.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_fire && tag_empty));
    assert property (@(posedge clk) disable iff (!rst_n) !(req_fire && tag_full));
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model plus in-order memory with programmable latency.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_instr, out_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    typedef struct packed { logic [31:0] addr; logic drop; } infl_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int checks = 0, errors = 0, cyc = 0, lat = 1;
    logic [31:0]  pc_m;
    infl_t        infl[$];
    fetch_entry_t bufq[$];
    mreq_t        memq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model + memory + compare, evaluated mid-cycle when everything is settled.
    initial begin
        infl_t f;
        logic  e_req, e_ov;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_req_valid", imem_req_valid, 0);
                chk("rst_out_instr", out_instr, NOP_INSTR);
                chk("rst_out_pc", out_pc, 0);
                pc_m = RPC;
                infl.delete();
                bufq.delete();
                memq.delete();
            end else begin
                e_req = !redirect_valid && (infl.size() + bufq.size() < DEPTH);
                e_ov  = bufq.size() > 0;
                chk("req_valid", imem_req_valid, e_req);
                if (e_req) chk("req_addr", imem_req_addr, pc_m);
                chk("out_valid", out_valid, e_ov);
                if (e_ov) begin
                    chk("out_instr", out_instr, bufq[0].instr);
                    chk("out_pc", out_pc, bufq[0].pc);
                end
                if (e_ov && out_ready && !redirect_valid) void'(bufq.pop_front());
                if (imem_rsp_valid) begin
                    if (infl.size() == 0) timeout("rsp_without_request");
                    else begin
                        f = infl.pop_front();
                        if (!f.drop && !redirect_valid)
                            bufq.push_back('{instr: imem_rsp_data, pc: f.addr});
                    end
                end
                if (redirect_valid) begin
                    bufq.delete();
                    foreach (infl[i]) infl[i].drop = 1'b1;
                    pc_m = {redirect_pc[31:2], 2'b00};
                end else if (e_req && imem_req_ready) begin
                    infl.push_back('{addr: pc_m, drop: 1'b0});
                    pc_m = pc_m + 32'd4;
                end
                if (imem_rsp_valid && memq.size() > 0) void'(memq.pop_front());
                if (imem_req_valid && imem_req_ready) memq.push_back('{addr: imem_req_addr, due: cyc + lat});
            end
            @(posedge clk);
            #1;
            if (rst_n && memq.size() > 0 && memq[0].due <= cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(memq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    initial begin
        logic [31:0] seen[$];
        bit ok;
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        repeat (3) tick();

        // Reset release and first streaming cycles (1-cycle memory, credit of 2)
        rst_n = 1'b1;
        @(negedge clk);
        chk("c0_req_valid", imem_req_valid, 1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("c1_req_addr", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("c2_out_valid", out_valid, 1);
        chk("c2_out_pc", out_pc, 32'h0);
        chk("c2_out_instr", out_instr, 32'hA5A5_A5A5);
        chk("c2_req_valid", imem_req_valid, 0);
        @(negedge clk);
        chk("c3_out_pc", out_pc, 32'h4);
        chk("c3_req_addr", imem_req_addr, 32'h8);
        repeat (8) tick();
        imem_req_ready = 1'b0;
        repeat (2) tick();
        imem_req_ready = 1'b1;
        repeat (6) tick();

        // Backpressure: buffer fills, requests stop, then drains in order
        out_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_out_valid", out_valid, 1);
        tick();
        out_ready = 1'b1;
        repeat (8) tick();

        // Redirect with two requests in flight (slow memory)
        lat = 3;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (infl.size() == 2) ok = 1;
        end
        if (!ok) timeout("two_in_flight");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                ok = 1;
                chk("redir_first_req", imem_req_addr, 32'h100);
            end
        end
        if (!ok) timeout("redir_first_req");
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                chk("redir_first_out_pc", out_pc, 32'h100);
                chk("redir_first_out_instr", out_instr, 32'hA5A5_A4A5);
            end
        end
        if (!ok) timeout("redir_first_out");
        repeat (6) tick();

        // Redirect coinciding with a response, then a second redirect one cycle later
        lat = 1;
        repeat (6) tick();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            #1;
            if (imem_rsp_valid) ok = 1;
        end
        if (!ok) timeout("rsp_for_redirect");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0180;
        tick();
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                chk("dbl_redir_out_pc", out_pc, 32'h200);
            end
        end
        if (!ok) timeout("dbl_redir_out");
        repeat (4) tick();
        @(negedge clk);
        chk("drop_cnt_zero", 32'(dut.drop_cnt), 0);

        // PC wrap across the top of the address space
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && seen.size() < 3; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) seen.push_back(imem_req_addr);
        end
        if (seen.size() < 3) timeout("wrap_reqs");
        else begin
            chk("wrap_req0", seen[0], 32'hFFFF_FFF8);
            chk("wrap_req1", seen[1], 32'hFFFF_FFFC);
            chk("wrap_req2", seen[2], 32'h0000_0000);
        end
        repeat (4) tick();

        // Reset pulse mid-stream
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req_valid", imem_req_valid, 0);
        chk("midrst_out_instr", out_instr, NOP_INSTR);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_req_valid", imem_req_valid, 1);
        chk("postrst_req_addr", imem_req_addr, RPC);
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
